// File: rtl/cps_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cps_pkg
// Description : Shared definitions for counter_priority_sequencer: FSM state
//               encoding, parameter defaults and increment direction codes.
// Revision    : 1.0 - initial release
// ============================================================================
package cps_pkg;

    // Parameter defaults
    localparam int c_NREQ_DEFAULT = 16;
    localparam int c_IDXW_DEFAULT = 5;

    // Sequencer state encoding
    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    // Increment direction as presented on CGNT_MINUS
    localparam logic c_DIR_PLUS  = 1'b0;
    localparam logic c_DIR_MINUS = 1'b1;

endpackage : cps_pkg
`default_nettype wire

// File: rtl/cps_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : cps_prio_enc
// Description : Combinational lowest-index-first priority encoder. Returns the
//               index of the lowest set request bit and a valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cps_prio_enc
    import cps_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT,
    parameter int IDXW = c_IDXW_DEFAULT
) (
    input  logic [NREQ-1:0] i_req,
    output logic [IDXW-1:0] o_idx,
    output logic            o_valid
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDXW'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule : cps_prio_enc
`default_nettype wire

// File: rtl/counter_priority_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_priority_sequencer
// Description : Queues plus/minus counter increment pulses per source and
//               issues one grant per memory cycle to the lowest pending index,
//               holding it until the datapath signals completion.
//               Optional feature macro: CPS_OVERRUN_EN (adds sticky COVRN
//               per-source overrun flags and retains opposing requests).
// Revision    : 1.0 - initial release
// ============================================================================
module counter_priority_sequencer
    import cps_pkg::*;
#(
    parameter int NREQ = c_NREQ_DEFAULT,
    parameter int IDXW = c_IDXW_DEFAULT
) (
    input  logic            SIM_CLK,
    input  logic            SIM_RST,
    input  logic            MCT_STB,
    input  logic            GOJAM,
    input  logic            INHINC,
    input  logic [NREQ-1:0] REQP,
    input  logic [NREQ-1:0] REQM,
    input  logic            CDONE,
    output logic            CGNT,
    output logic [IDXW-1:0] CGNT_IDX,
    output logic            CGNT_MINUS,
    output logic            CPEND,
`ifdef CPS_OVERRUN_EN
    output logic [NREQ-1:0] COVRN,
`endif
    output logic            CSTALL
);

    logic [NREQ-1:0] r_pp;
    logic [NREQ-1:0] r_pm;
    logic [NREQ-1:0] w_pp_nxt;
    logic [NREQ-1:0] w_pm_nxt;
    logic [NREQ-1:0] w_any;
    logic [NREQ-1:0] w_win_oh;
    logic [IDXW-1:0] w_idx;
    logic            w_valid;
    logic            w_grant;
    logic            w_win_minus;
    logic            w_bit_pp;
    logic            w_bit_pm;

    logic [0:0]      r_state;
    logic            r_cgnt;
    logic [IDXW-1:0] r_cgnt_idx;
    logic            r_cgnt_minus;
    logic            r_cstall;

`ifdef CPS_OVERRUN_EN
    logic [NREQ-1:0] r_covrn;
    logic [NREQ-1:0] w_ovr_set;
`endif

    assign w_any = r_pp | r_pm;

    cps_prio_enc #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_prio_enc (
        .i_req   (w_any),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign CPEND   = w_valid;
    assign w_grant = (r_state == c_ST_IDLE) && MCT_STB && !INHINC && !GOJAM && w_valid;

    // Next pending bits: clear the granted bit first, then apply captures on top
    always_comb begin
        w_pp_nxt    = r_pp;
        w_pm_nxt    = r_pm;
        w_win_oh    = '0;
        w_bit_pp    = 1'b0;
        w_bit_pm    = 1'b0;
`ifdef CPS_OVERRUN_EN
        w_ovr_set   = '0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            w_win_oh[i] = w_grant && (w_idx == IDXW'(i));
        end
        // Plus direction wins when both bits are held for the winner
        w_win_minus = (|(r_pp & w_win_oh)) ? c_DIR_PLUS : c_DIR_MINUS;

        for (int i = 0; i < NREQ; i++) begin
            w_bit_pp = r_pp[i];
            w_bit_pm = r_pm[i];
            if (w_win_oh[i]) begin
                if (w_bit_pp) begin
                    w_bit_pp = 1'b0;
                end else begin
                    w_bit_pm = 1'b0;
                end
            end
            case ({REQP[i], REQM[i]})
                2'b10: begin
                    if (w_bit_pp) begin
`ifdef CPS_OVERRUN_EN
                        w_ovr_set[i] = 1'b1;
`endif
                    end else if (w_bit_pm) begin
`ifdef CPS_OVERRUN_EN
                        w_bit_pp     = 1'b1;
                        w_ovr_set[i] = 1'b1;
`else
                        w_bit_pm     = 1'b0;
`endif
                    end else begin
                        w_bit_pp = 1'b1;
                    end
                end
                2'b01: begin
                    if (w_bit_pm) begin
`ifdef CPS_OVERRUN_EN
                        w_ovr_set[i] = 1'b1;
`endif
                    end else if (w_bit_pp) begin
`ifdef CPS_OVERRUN_EN
                        w_bit_pm     = 1'b1;
                        w_ovr_set[i] = 1'b1;
`else
                        w_bit_pp     = 1'b0;
`endif
                    end else begin
                        w_bit_pm = 1'b1;
                    end
                end
                default: begin
                    // No request, or opposing pair that nets to zero
                end
            endcase
            w_pp_nxt[i] = w_bit_pp;
            w_pm_nxt[i] = w_bit_pm;
        end
    end

    // Pending bit registers; GOJAM wipes queued work and drops same-cycle captures
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_pp <= '0;
            r_pm <= '0;
        end else if (GOJAM) begin
            r_pp <= '0;
            r_pm <= '0;
        end else begin
            r_pp <= w_pp_nxt;
            r_pm <= w_pm_nxt;
        end
    end

`ifdef CPS_OVERRUN_EN
    // Sticky overrun flags, cleared only by restart or reset
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_covrn <= '0;
        end else if (GOJAM) begin
            r_covrn <= '0;
        end else begin
            r_covrn <= r_covrn | w_ovr_set;
        end
    end

    assign COVRN = r_covrn;
`endif

    // Grant state machine with registered grant and stall outputs
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            r_state      <= c_ST_IDLE;
            r_cgnt       <= 1'b0;
            r_cgnt_idx   <= '0;
            r_cgnt_minus <= 1'b0;
            r_cstall     <= 1'b0;
        end else begin
            r_cstall <= 1'b0;
            if (GOJAM) begin
                r_state      <= c_ST_IDLE;
                r_cgnt       <= 1'b0;
                r_cgnt_idx   <= '0;
                r_cgnt_minus <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_grant) begin
                            r_state      <= c_ST_BUSY;
                            r_cgnt       <= 1'b1;
                            r_cgnt_idx   <= w_idx;
                            r_cgnt_minus <= w_win_minus;
                        end
                    end
                    c_ST_BUSY: begin
                        r_cstall <= MCT_STB && w_valid;
                        if (CDONE) begin
                            r_state <= c_ST_IDLE;
                            r_cgnt  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_cgnt  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign CGNT       = r_cgnt;
    assign CGNT_IDX   = r_cgnt_idx;
    assign CGNT_MINUS = r_cgnt_minus;
    assign CSTALL     = r_cstall;

endmodule : counter_priority_sequencer
`default_nettype wire

// File: tb/tb_counter_priority_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_priority_sequencer
// Description : Self-checking bench for counter_priority_sequencer with a
//               behavioural pending-queue model (CPS_OVERRUN_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_priority_sequencer;

    localparam int NREQ = 16;
    localparam int IDXW = 5;

    logic            SIM_CLK = 1'b0;
    logic            SIM_RST;
    logic            MCT_STB;
    logic            GOJAM;
    logic            INHINC;
    logic [NREQ-1:0] REQP;
    logic [NREQ-1:0] REQM;
    logic            CDONE;
    logic            CGNT;
    logic [IDXW-1:0] CGNT_IDX;
    logic            CGNT_MINUS;
    logic            CPEND;
    logic            CSTALL;
`ifdef CPS_OVERRUN_EN
    logic [NREQ-1:0] COVRN;
`endif

    counter_priority_sequencer #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) dut (
        .SIM_CLK    (SIM_CLK),
        .SIM_RST    (SIM_RST),
        .MCT_STB    (MCT_STB),
        .GOJAM      (GOJAM),
        .INHINC     (INHINC),
        .REQP       (REQP),
        .REQM       (REQM),
        .CDONE      (CDONE),
        .CGNT       (CGNT),
        .CGNT_IDX   (CGNT_IDX),
        .CGNT_MINUS (CGNT_MINUS),
        .CPEND      (CPEND),
`ifdef CPS_OVERRUN_EN
        .COVRN      (COVRN),
`endif
        .CSTALL     (CSTALL)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    // Reference model: pending sets per source plus the current grant
    bit [NREQ-1:0] m_pp;
    bit [NREQ-1:0] m_pm;
    bit [NREQ-1:0] m_ovr;
    bit            m_busy;
    int            m_idx;
    bit            m_minus;
    bit            m_stall;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pp    = '0;
        m_pm    = '0;
        m_ovr   = '0;
        m_busy  = 1'b0;
        m_idx   = 0;
        m_minus = 1'b0;
        m_stall = 1'b0;
    endtask

    task automatic check_all();
        chk("cgnt", 32'(CGNT), 32'(m_busy));
        chk("cpend", 32'(CPEND), 32'(|(m_pp | m_pm)));
        chk("cstall", 32'(CSTALL), 32'(m_stall));
        if (m_busy) begin
            chk("cgnt_idx", 32'(CGNT_IDX), 32'(m_idx));
            chk("cgnt_minus", 32'(CGNT_MINUS), 32'(m_minus));
        end
`ifdef CPS_OVERRUN_EN
        chk("covrn", 32'(COVRN), 32'(m_ovr));
`endif
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge
    task automatic step(input logic [NREQ-1:0] rp, input logic [NREQ-1:0] rm,
                        input bit stb, input bit gj, input bit inh, input bit dn);
        bit [NREQ-1:0] pp;
        bit [NREQ-1:0] pm;
        bit            stall;
        bit            pend;
        REQP    = rp;
        REQM    = rm;
        MCT_STB = stb;
        GOJAM   = gj;
        INHINC  = inh;
        CDONE   = dn;
        pp      = m_pp;
        pm      = m_pm;
        stall   = 1'b0;
        if (gj) begin
            pp     = '0;
            pm     = '0;
            m_ovr  = '0;
            m_busy = 1'b0;
        end else begin
            pend  = |(m_pp | m_pm);
            stall = m_busy && stb && pend;
            if (!m_busy && stb && !inh && pend) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (pp[i] || pm[i]) begin
                        m_idx   = i;
                        m_minus = !pp[i];
                        if (pp[i]) pp[i] = 1'b0;
                        else       pm[i] = 1'b0;
                        break;
                    end
                end
                m_busy = 1'b1;
            end else if (m_busy && dn) begin
                m_busy = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (rp[i] && !rm[i]) begin
                    if (pp[i]) m_ovr[i] = 1'b1;
                    else if (pm[i]) begin
`ifdef CPS_OVERRUN_EN
                        pp[i] = 1'b1; m_ovr[i] = 1'b1;
`else
                        pm[i] = 1'b0;
`endif
                    end else pp[i] = 1'b1;
                end else if (rm[i] && !rp[i]) begin
                    if (pm[i]) m_ovr[i] = 1'b1;
                    else if (pp[i]) begin
`ifdef CPS_OVERRUN_EN
                        pm[i] = 1'b1; m_ovr[i] = 1'b1;
`else
                        pp[i] = 1'b0;
`endif
                    end else pm[i] = 1'b1;
                end
            end
`ifndef CPS_OVERRUN_EN
            m_ovr = '0;
`endif
        end
        m_pp    = pp;
        m_pm    = pm;
        m_stall = stall;
        @(posedge SIM_CLK);
        #1;
        REQP = '0; REQM = '0; MCT_STB = 1'b0; GOJAM = 1'b0; INHINC = 1'b0; CDONE = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [NREQ-1:0] bitn(input int n);
        logic [NREQ-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [NREQ-1:0] rp;
        logic [NREQ-1:0] rm;
        bit              stb;
        bit              gj;
        bit              inh;
        bit              dn;

        REQP = '0; REQM = '0; MCT_STB = 1'b0; GOJAM = 1'b0; INHINC = 1'b0; CDONE = 1'b0;
        SIM_RST = 1'b1;
        model_reset();
        repeat (3) @(posedge SIM_CLK);
        #1;
        chk("rst_cgnt", 32'(CGNT), 32'd0);
        chk("rst_idx", 32'(CGNT_IDX), 32'd0);
        chk("rst_minus", 32'(CGNT_MINUS), 32'd0);
        chk("rst_cpend", 32'(CPEND), 32'd0);
        chk("rst_cstall", 32'(CSTALL), 32'd0);
        SIM_RST = 1'b0;
        idle(2);

        // Single request: REQP[3], strobe two cycles later, done later
        step(bitn(3), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_pend", 32'(CPEND), 32'd1);
        idle(1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_cgnt", 32'(CGNT), 32'd1);
        chk("single_idx", 32'(CGNT_IDX), 32'd3);
        chk("single_minus", 32'(CGNT_MINUS), 32'd0);
        idle(2);
        chk("single_hold_idx", 32'(CGNT_IDX), 32'd3);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_done", 32'(CGNT), 32'd0);
        chk("single_empty", 32'(CPEND), 32'd0);

        // Priority: REQM[7] with REQP[2]
        step(bitn(2), bitn(7), 1'b0, 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("prio1_idx", 32'(CGNT_IDX), 32'd2);
        chk("prio1_minus", 32'(CGNT_MINUS), 32'd0);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("prio2_idx", 32'(CGNT_IDX), 32'd7);
        chk("prio2_minus", 32'(CGNT_MINUS), 32'd1);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("prio3_nogrant", 32'(CGNT), 32'd0);

        // Cancel: REQP[5] then REQM[5]
        step(bitn(5), '0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifndef CPS_OVERRUN_EN
        step('0, bitn(5), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("cancel_pend", 32'(CPEND), 32'd0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cancel_nogrant", 32'(CGNT), 32'd0);
`else
        step('0, bitn(5), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("both_held_ovr", 32'(COVRN[5]), 32'd1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("both_plus_first", 32'(CGNT_MINUS), 32'd0);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("both_minus_next", 32'(CGNT_MINUS), 32'd1);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Request-to-grant: request and strobe in same cycle gives no grant
        step(bitn(1), '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("same_cycle_nogrant", 32'(CGNT), 32'd0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_grant_idx", 32'(CGNT_IDX), 32'd1);
        // Stall: strobe while busy with REQP[0] pending
        step(bitn(0), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("stall_pulse", 32'(CSTALL), 32'd1);
        chk("stall_idx_kept", 32'(CGNT_IDX), 32'd1);
        idle(1);
        chk("stall_one_cycle", 32'(CSTALL), 32'd0);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Inhibit: strobe ignored, pending kept
        step('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("inh_nogrant", 32'(CGNT), 32'd0);
        chk("inh_pend", 32'(CPEND), 32'd1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("inh_then_grant", 32'(CGNT_IDX), 32'd0);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

        // GOJAM mid-grant with pending 1, 4, 9 and a simultaneous REQP[6]
        step(bitn(1) | bitn(4) | bitn(9), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gj_pre_cgnt", 32'(CGNT), 32'd1);
        step(bitn(6), '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("gj_cgnt", 32'(CGNT), 32'd0);
        chk("gj_cpend", 32'(CPEND), 32'd0);

`ifdef CPS_OVERRUN_EN
        step(bitn(4), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(bitn(4), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_set", 32'(COVRN[4]), 32'd1);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_sticky", 32'(COVRN[4]), 32'd1);
        step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovr_gj_clear", 32'(COVRN), 32'd0);
`endif

        // Asynchronous reset in the middle of a grant
        step(bitn(12), '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("arst_pre", 32'(CGNT), 32'd1);
        #2;
        SIM_RST = 1'b1;
        #1;
        chk("arst_cgnt", 32'(CGNT), 32'd0);
        chk("arst_idx", 32'(CGNT_IDX), 32'd0);
        chk("arst_cpend", 32'(CPEND), 32'd0);
        model_reset();
        @(posedge SIM_CLK);
        #1;
        SIM_RST = 1'b0;
        idle(1);

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            rp  = NREQ'($urandom & $urandom & $urandom);
            rm  = NREQ'($urandom & $urandom & $urandom);
            stb = ($urandom_range(0, 2) == 0);
            gj  = ($urandom_range(0, 59) == 0);
            inh = ($urandom_range(0, 7) == 0);
            dn  = m_busy && ($urandom_range(0, 2) == 0);
            step(rp, rm, stb, gj, inh, dn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_counter_priority_sequencer
`default_nettype wire

// File: doc/counter_priority_sequencer.md
# counter_priority_sequencer

Schedules involuntary counter increments (plus/minus pulses from up to NREQ counter sources) onto the single shared counter-update datapath, one grant per memory cycle. Sits beside the timer: it starts a grant only on the memory-cycle strobe derived from T12, and it holds the grant until the datapath reports completion. GOJAM discards all queued work.

## Interface
Parameters:
- NREQ, 16, number of counter request sources (2..32)
- IDXW, 5, width of grant index; must satisfy 2^IDXW >= NREQ

Ports:
- SIM_CLK  in  1  system clock
- SIM_RST  in  1  asynchronous, active-high reset
- MCT_STB  in  1  one-cycle strobe at start of each memory cycle (T12 boundary)
- GOJAM  in  1  restart; synchronous clear of all pending and grant state
- INHINC  in  1  inhibit increments; a strobe seen while high is skipped
- REQP  in  NREQ  one-cycle plus-increment request pulses, one bit per source
- REQM  in  NREQ  one-cycle minus-increment request pulses
- CDONE  in  1  datapath completion, one cycle, valid only while CGNT=1
- CGNT  out  1  grant active
- CGNT_IDX  out  IDXW  granted source index
- CGNT_MINUS  out  1  1 = minus increment, 0 = plus
- CPEND  out  1  OR of all pending bits
- CSTALL  out  1  one-cycle pulse: strobe arrived while BUSY with work pending

## Operation
- Per source: two pending bits PP[i], PM[i]. Reset value 0.
- Request capture (cycle t, visible t+1):
  - REQP[i] sets PP[i] unless PM[i]=1, in which case PM[i] clears (net zero).
  - REQM[i] is symmetric.
  - REQP[i] and REQM[i] together leave both bits unchanged.
  - A request on an already-set bit in the same direction is absorbed.
- State machine: IDLE, BUSY.
  - IDLE -> BUSY when MCT_STB=1, INHINC=0, GOJAM=0 and any bit is pending.
  - BUSY -> IDLE on CDONE=1 or GOJAM=1.
- Selection: the lowest index i with PP[i] or PM[i] set wins. If both are set, PP wins; a both-set state is only reachable via the overrun path below.
- On the grant edge, the winning bit clears. A request for the same source arriving in that same cycle re-sets the bit; capture takes priority over clear.
- GOJAM clears PP, PM, CGNT and state, and suppresses captures in the same cycle.
- Reset values: CGNT=0, CGNT_IDX=0, CGNT_MINUS=0, CPEND=0, CSTALL=0, state IDLE.

## Timing
- Grant latency: strobe at cycle t -> CGNT, CGNT_IDX and CGNT_MINUS registered at t+1.
- Request-to-grant: a request at t is eligible for a strobe at t+1 or later, not at t.
- CGNT_IDX and CGNT_MINUS are stable for the whole time CGNT=1.
- CDONE at t -> CGNT=0 at t+1. A new grant can start at t+1 only if MCT_STB also occurs at t+1.
- MCT_STB while BUSY: no grant. CSTALL pulses at t+1 if CPEND=1.
- CDONE while IDLE: ignored.
- CPEND is combinational from the registered pending bits.
- SIM_RST mid-grant: all outputs return to reset values immediately (asynchronous).

## Configuration
- CPS_OVERRUN_EN defined:
  - Adds output COVRN [NREQ], a sticky per-source overrun flag.
  - COVRN[i] sets when a request hits an already-set bit in the same direction, or when PP and PM would both need to be held.
  - In the both-held case, the opposing bit is retained rather than cancelled, so both PP and PM are set.
  - COVRN is cleared only by GOJAM or SIM_RST.
- Not defined:
  - No COVRN port; same-direction repeats are silently absorbed and opposing requests always cancel.
  - PP and PM are never both set.

## Structure
- Package cps_pkg: state enum (IDLE, BUSY), defaults for NREQ and IDXW, direction encoding constants (DIR_PLUS=0, DIR_MINUS=1).
- Sub-module cps_prio_enc: combinational lowest-index-first encoder over NREQ bits, producing index and valid. Instantiated once on PP|PM.

## Test plan
- Single request: REQP[3] at t, MCT_STB at t+2 -> CGNT=1, IDX=3, MINUS=0 at t+3. CDONE at t+5 -> CGNT=0 at t+6, CPEND=0.
- Priority: REQM[7] and REQP[2] in the same cycle, then three strobe/CDONE rounds -> grants IDX=2 (plus), then IDX=7 (minus), then no grant.
- Cancel: REQP[5] at t, REQM[5] at t+1 -> CPEND=0 at t+2; a later strobe produces no grant.
- Stall and inhibit:
  - Strobe while BUSY with REQP[0] pending -> CSTALL pulse, grant unchanged.
  - Strobe with INHINC=1 -> no grant, pending kept.
- GOJAM mid-grant: CGNT=1, pending on 1, 4 and 9, GOJAM pulse -> next cycle CGNT=0, CPEND=0. A simultaneous REQP[6] is dropped.
- With CPS_OVERRUN_EN: REQP[4] twice before any grant -> COVRN[4]=1, which persists through the grant. GOJAM clears it.
